// File: rtl/reg_bank_if.sv
// rtl/reg_bank_if.sv - write, reservation and dual read port bundle for reg_bank
interface reg_bank_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
);
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;
    logic [AW-1:0]    ra_addr;
    logic [WIDTH-1:0] ra_data;
    logic             ra_ready;
    logic [AW-1:0]    rb_addr;
    logic [WIDTH-1:0] rb_data;
    logic             rb_ready;
    logic             rsv_stall;
    logic             busy_any;

    modport master (
        output wr_en, wr_addr, wr_data, rsv_en, rsv_addr, ra_addr, rb_addr,
        input  ra_data, ra_ready, rb_data, rb_ready, rsv_stall, busy_any
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr, ra_addr, rb_addr,
        output ra_data, ra_ready, rb_data, rb_ready, rsv_stall, busy_any
    );
endinterface

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - register bank with per-entry pending bits, write bypass and optional zero register (REG_BANK_R0_ZERO_EN)
module reg_bank #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       clr,
    reg_bank_if.slave  bus
);

`ifdef REG_BANK_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_pend;

    logic             w_wr_ok;
    logic             w_rsv_ok;
    logic             w_rsv_pend;
    logic [WIDTH:0]   w_ra;
    logic [WIDTH:0]   w_rb;

    // Addresses beyond the last register map to nothing.
    function automatic logic f_in_range(input logic [AW-1:0] addr);
        return (AW+1)'(addr) < (AW+1)'(DEPTH);
    endfunction

    // Register 0 is excluded from writes and reservations when it is the zero register.
    function automatic logic f_is_r0(input logic [AW-1:0] addr);
        return R0_ZERO && (addr == '0);
    endfunction

    // One read port: {ready, data}, with same-cycle write bypass.
    function automatic logic [WIDTH:0] f_read(input logic [AW-1:0] addr);
        logic [WIDTH:0] res;
        res = {1'b1, {WIDTH{1'b0}}};
        if (f_in_range(addr) && !f_is_r0(addr)) begin
            if (w_wr_ok && (bus.wr_addr == addr))
                res = {1'b1, bus.wr_data};
            else
                res = {~r_pend[addr], r_mem[addr]};
        end
        return res;
    endfunction

    // Qualify the write and reservation requests against the address map.
    always_comb begin
        w_wr_ok    = bus.wr_en && f_in_range(bus.wr_addr) && !f_is_r0(bus.wr_addr);
        w_rsv_ok   = bus.rsv_en && f_in_range(bus.rsv_addr) && !f_is_r0(bus.rsv_addr);
        w_rsv_pend = 1'b0;
        if (w_rsv_ok)
            w_rsv_pend = r_pend[bus.rsv_addr];
    end

    // A reservation on a pending entry stalls, unless the same cycle's write retires it.
    always_comb begin
        bus.rsv_stall = w_rsv_ok && w_rsv_pend &&
                        !(w_wr_ok && (bus.wr_addr == bus.rsv_addr));
    end

    // Both read ports share the same lookup so they always agree.
    always_comb begin
        w_ra         = f_read(bus.ra_addr);
        w_rb         = f_read(bus.rb_addr);
        bus.ra_ready = w_ra[WIDTH];
        bus.ra_data  = w_ra[WIDTH-1:0];
        bus.rb_ready = w_rb[WIDTH];
        bus.rb_data  = w_rb[WIDTH-1:0];
        bus.busy_any = |r_pend;
    end

    // Storage update; the reservation is applied after the write so a same-address
    // pair leaves the entry pending, and re-setting an already pending bit is a no-op.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_mem  <= '{default: '0};
            r_pend <= '0;
        end else begin
            if (w_wr_ok) begin
                r_mem[bus.wr_addr]  <= bus.wr_data;
                r_pend[bus.wr_addr] <= 1'b0;
            end
            if (w_rsv_ok)
                r_pend[bus.rsv_addr] <= 1'b1;
        end
    end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter WIDTH, default 32: data width of every register and data port in bits.
REQ-002 Parameter DEPTH, default 16: number of registers; legal range is 2..256.
REQ-003 Parameter AW, default $clog2(DEPTH): address width of every address port.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 clr  in  1  reset, synchronous and active-high.
REQ-006 wr_en  in  1  write strobe for the write port.
REQ-007 wr_addr  in  AW  write address.
REQ-008 wr_data  in  WIDTH  write data.
REQ-009 rsv_en  in  1  reservation request; marks rsv_addr as pending.
REQ-010 rsv_addr  in  AW  reservation address.
REQ-011 ra_addr  in  AW  read port A address.
REQ-012 ra_data  out  WIDTH  read port A data.
REQ-013 ra_ready  out  1  read port A value is valid (not pending).
REQ-014 rb_addr, rb_data, rb_ready  in/out/out  AW/WIDTH/1  read port B, identical to port A.
REQ-015 rsv_stall  out  1  reservation refused because the target is already pending.
REQ-016 busy_any  out  1  at least one register is pending.

Function
REQ-017 The block SHALL hold DEPTH registers of WIDTH bits plus one pending bit per register.
REQ-018 wr_en=1 SHALL write wr_data to register wr_addr at the next rising edge, with 1-cycle latency, and SHALL clear pending[wr_addr] at that edge.
REQ-019 Read ports SHALL be combinational from the stored state.
REQ-020 Bypass: if wr_en=1 and wr_addr equals a read address in the same cycle, that port SHALL output wr_data and ready=1.
REQ-021 Otherwise, rX_ready SHALL equal the inverse of pending[rX_addr].
REQ-022 rsv_en=1 with pending[rsv_addr]=0 SHALL set pending[rsv_addr] at the next edge.
REQ-023 rsv_en=1 with pending[rsv_addr]=1 SHALL assert rsv_stall combinationally in the same cycle and SHALL leave state unchanged, unless REQ-024 applies.
REQ-024 If rsv_en=1 and wr_en=1 in the same cycle with rsv_addr equal to wr_addr, data SHALL be written, pending SHALL be 1 after the edge, and rsv_stall SHALL be 0.
REQ-025 If rsv_en=1 and wr_en=1 target different addresses, both actions SHALL take effect independently at the same edge.
REQ-026 rsv_stall SHALL be 0 whenever rsv_en=0.
REQ-027 busy_any SHALL equal the OR of all pending bits as registered, with no bypass.
REQ-028 Addresses at or above DEPTH SHALL be handled as follows: writes and reservations are ignored, rsv_stall is 0, and reads return 0 with ready=1.
REQ-029 Two read ports addressing the same register SHALL return identical data and ready.

Reset
REQ-030 clr=1 at a rising edge SHALL set all registers to 0 and all pending bits to 0.
REQ-031 clr SHALL dominate wr_en and rsv_en in the same cycle; neither takes effect.
REQ-032 After that edge, all ready outputs SHALL be 1, busy_any SHALL be 0, and data outputs SHALL be 0 (bypass excepted).
REQ-033 Reset asserted mid-reservation SHALL discard all pending state; no write is required afterwards.

Configuration
REQ-034 With macro REG_BANK_R0_ZERO_EN defined, register 0 SHALL behave as a hardwired zero register:
- reads of address 0 return 0 with ready=1, including during a same-cycle write to address 0 (no bypass);
- writes and reservations to address 0 are ignored;
- rsv_stall is never asserted for address 0.
REQ-035 Without the macro, register 0 SHALL behave as any other register.

Verification
REQ-036 clr=1 for one edge after arbitrary writes and reservations -> all reads return 0, all ready=1, busy_any=0.
REQ-037 Write 0xDEADBEEF to r5, then read ra_addr=5 and rb_addr=5 -> both return 0xDEADBEEF, ready=1; in the write cycle itself, bypass returns 0xDEADBEEF.
REQ-038 Reserve r3, next cycle reserve r3 again -> rsv_stall=1, ra_addr=3 gives ra_ready=0, busy_any=1; write r3=7 -> ready=1, data 7, busy_any=0.
REQ-039 rsv_en and wr_en to r9 in the same cycle with data 0x55 -> after the edge r9 reads 0x55 with ready=0.
REQ-040 With REG_BANK_R0_ZERO_EN: write 0x1234 to r0 and reserve r0 -> r0 reads 0, ready=1, busy_any=0, rsv_stall=0.
REQ-041 DEPTH=12: write addr 14 and read addr 14 -> returns 0, ready=1, no register changed.
